// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if
// Bundles the serial line, the per-frame configuration inputs and the
// received-data / status outputs of the UART receive frame controller.
//   master : drives RX_In, PAR_EN, PAR_TYP, STOP2, Prescale; observes results
//   slave  : the receiver itself
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
);
    logic                  RX_In;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [PRESC_W-1:0]    Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Parity_Error;
    logic                  Stop_Error;
    logic                  Break_Det;
    logic                  Busy;

    modport master (
        output RX_In, PAR_EN, PAR_TYP, STOP2, Prescale,
        input  P_DATA, Data_Valid, Parity_Error, Stop_Error, Break_Det, Busy
    );

    modport slave (
        input  RX_In, PAR_EN, PAR_TYP, STOP2, Prescale,
        output P_DATA, Data_Valid, Parity_Error, Stop_Error, Break_Det, Busy
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// UART receive frame controller: oversampled edge/bit counting, 3-point
// majority sampling, LSB-first deserialisation, runtime even/odd parity and
// one/two stop bit checking.  Optional line-break detection is compiled in
// with the macro UART_RX_BREAK_DET_EN.
// Ports:
//   CLK  - oversampling clock
//   RST  - asynchronous active-low reset
//   bus  - uart_rx_frame_ctrl_if.slave: RX_In, PAR_EN, PAR_TYP, STOP2,
//          Prescale in; P_DATA, Data_Valid, Parity_Error, Stop_Error,
//          Break_Det, Busy out
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line idle, waiting for a falling start edge
// START    | checking the start bit, glitches fall back to IDLE
// DATA     | shifting in DATA_WIDTH data bits
// PARITY   | checking the parity bit
// STOP     | checking one or two stop bits
// DONE     | one cycle, publishes the frame result
// BRK_WAIT | line break seen, wait for the line to return high
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               CLK,
    input  logic               RST,
    uart_rx_frame_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        DONE     = 3'd5
`ifdef UART_RX_BREAK_DET_EN
        ,
        BRK_WAIT = 3'd6
`endif
    } state_t;

    localparam logic [3:0] DW = 4'(DATA_WIDTH);

    state_t                state, next_state;
    logic [PRESC_W-1:0]    edge_cnt, half;
    logic [3:0]            bit_cnt, stop_first, stop_last;
    logic [2:0]            smp;
    logic [DATA_WIDTH-1:0] shreg, p_data_q;
    logic                  cfg_par_en, cfg_par_typ, cfg_stop2;
    logic                  par_err, stop_err;
    logic                  dv_q, pe_q, se_q;
    logic                  load_cfg, active, last_edge, done_edge;
    logic                  sample_pt, decide, bit_val, brk;

    assign half      = bus.Prescale >> 1;
    assign last_edge = (edge_cnt == bus.Prescale - PRESC_W'(1));
    // The last stop bit ends one edge early so a back-to-back start edge
    // can still be caught from DONE.
    assign done_edge = (edge_cnt == bus.Prescale - PRESC_W'(2));
    assign sample_pt = (edge_cnt == half - PRESC_W'(1)) || (edge_cnt == half) ||
                       (edge_cnt == half + PRESC_W'(1));
    assign decide    = (edge_cnt == half + PRESC_W'(2));
    assign bit_val   = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign active    = (state == START) || (state == DATA) ||
                       (state == PARITY) || (state == STOP);

    // Bit 0 is the start bit, so stop bits follow the data and parity bits.
    assign stop_first = DW + 4'd1 + {3'b000, cfg_par_en};
    assign stop_last  = stop_first + {3'b000, cfg_stop2};

`ifdef UART_RX_BREAK_DET_EN
    logic all_zero, bd_q;
    assign brk           = all_zero;
    assign bus.Break_Det = bd_q;
`else
    assign brk           = 1'b0;
    assign bus.Break_Det = 1'b0;
`endif

    assign bus.P_DATA       = p_data_q;
    assign bus.Data_Valid   = dv_q;
    assign bus.Parity_Error = pe_q;
    assign bus.Stop_Error   = se_q;
    assign bus.Busy         = (state != IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_cfg   = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.RX_In) begin
                    next_state = START;
                    load_cfg   = 1'b1;
                end
            end
            START: begin
                if (decide && bit_val) next_state = IDLE;
                else if (last_edge)    next_state = DATA;
            end
            DATA: begin
                if (last_edge && (bit_cnt == DW))
                    next_state = cfg_par_en ? PARITY : STOP;
            end
            PARITY: begin
                if (last_edge) next_state = STOP;
            end
            STOP: begin
                if ((bit_cnt == stop_last) && done_edge) next_state = DONE;
            end
            DONE: begin
`ifdef UART_RX_BREAK_DET_EN
                if (brk) next_state = BRK_WAIT;
                else
`endif
                if (!bus.RX_In) begin
                    next_state = START;
                    load_cfg   = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            BRK_WAIT: begin
                if (bus.RX_In) next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            smp         <= '0;
            shreg       <= '0;
            p_data_q    <= '0;
            cfg_par_en  <= 1'b0;
            cfg_par_typ <= 1'b0;
            cfg_stop2   <= 1'b0;
            par_err     <= 1'b0;
            stop_err    <= 1'b0;
            dv_q        <= 1'b0;
            pe_q        <= 1'b0;
            se_q        <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            all_zero    <= 1'b0;
            bd_q        <= 1'b0;
`endif
        end else begin
            if (active) begin
                if (last_edge) begin
                    edge_cnt <= '0;
                    bit_cnt  <= bit_cnt + 4'd1;
                end else begin
                    edge_cnt <= edge_cnt + PRESC_W'(1);
                end
            end else begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end

            if (active && sample_pt) smp <= {smp[1:0], bus.RX_In};

            if (load_cfg) begin
                cfg_par_en  <= bus.PAR_EN;
                cfg_par_typ <= bus.PAR_TYP;
                cfg_stop2   <= bus.STOP2;
                par_err     <= 1'b0;
                stop_err    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                all_zero    <= 1'b1;
`endif
            end

            if (decide) begin
                case (state)
                    DATA:    shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
                    PARITY:  if (bit_val != ((^shreg) ^ cfg_par_typ)) par_err <= 1'b1;
                    STOP:    if (!bit_val) stop_err <= 1'b1;
                    default: ;
                endcase
`ifdef UART_RX_BREAK_DET_EN
                // Only data, parity and the first stop bit count towards a break.
                if (bit_val && ((state == DATA) || (state == PARITY) ||
                                ((state == STOP) && (bit_cnt == stop_first))))
                    all_zero <= 1'b0;
`endif
            end

            dv_q <= 1'b0;
            pe_q <= 1'b0;
            se_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            bd_q <= 1'b0;
`endif
            if (state == DONE) begin
                dv_q <= !par_err && !stop_err && !brk;
                pe_q <= par_err && !brk;
                se_q <= stop_err;
`ifdef UART_RX_BREAK_DET_EN
                bd_q <= brk;
`endif
                if (!par_err && !stop_err && !brk) p_data_q <= shreg;
            end
        end
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Self-contained, parametrised UART receive frame controller for the UART_RX path. It is the successor to the fixed 8-bit receive FSM, and it absorbs edge/bit counting, 3-point majority sampling, deserialisation, and parity and stop checking into one block. Over the fixed version it adds:
- configurable data width
- runtime even/odd parity
- one or two stop bits
- an optional line-break detector

The block feeds the RX clock-domain data path (P_DATA / Data_Valid) and the error flags.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame; legal 5..9
- PRESC_W, 6, width of Prescale and of the internal edge counter

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  oversampling clock
- RST  in  1  asynchronous active-low reset
- RX_In  in  1  serial line, idle high
- PAR_EN  in  1  parity bit present
- PAR_TYP  in  1  0 = even, 1 = odd
- STOP2  in  1  0 = one stop bit, 1 = two stop bits
- Prescale  in  PRESC_W  oversampling ratio; legal even values 8..2^PRESC_W-2
- P_DATA  out  DATA_WIDTH  received word, LSB first on line; held until next valid frame
- Data_Valid  out  1  one-cycle pulse, frame good
- Parity_Error  out  1  one-cycle pulse, parity mismatch
- Stop_Error  out  1  one-cycle pulse, any stop bit sampled 0
- Break_Det  out  1  one-cycle pulse, line break (tied 0 unless macro set)
- Busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE, and BRK_WAIT (BRK_WAIT only when the macro is set).
- Edge counter: runs 0..Prescale-1 and wraps. At the wrap the bit counter increments. Both counters clear in IDLE and DONE.
- Sampling: RX_In is sampled at edges Prescale/2-1, Prescale/2 and Prescale/2+1. The bit value is the majority of the three, decided at edge Prescale/2+2.
- IDLE: RX_In = 0 moves to START. On that transition PAR_EN, PAR_TYP and STOP2 are latched. Changes to these inputs mid-frame are ignored until the next frame.
- START: if the decided bit is 1 (glitch), return to IDLE on the next cycle with no flag. Otherwise go to DATA at edge Prescale-1.
- DATA: at each decision point the decided bit shifts in LSB-first. After bit DATA_WIDTH, at edge Prescale-1, go to PARITY if PAR_EN is latched, otherwise to STOP.
- PARITY: the expected bit is XOR of the data, inverted when odd. A mismatch latches the parity error. Go to STOP at edge Prescale-1.
- STOP: checks 1 or 2 stop bits; any 0 latches the stop error. On the last stop bit, go to DONE at edge Prescale-2, which leaves margin for a back-to-back start.
- DONE lasts one cycle. It registers the flags: Data_Valid = no parity error and no stop error, plus the Parity_Error and Stop_Error pulses. P_DATA is updated only when the frame is valid. Next state is START if RX_In = 0, otherwise IDLE. The latched configuration is re-latched on the DONE→START transition.
- Reset (any time, including mid-frame): state goes to IDLE, counters and shift register clear, and every output is 0, including P_DATA.

## Timing
- Cycle 0 is the edge where IDLE samples RX_In = 0; START begins at cycle 1 with edge 0.
- Frame bits B = 1 + DATA_WIDTH + PAR_EN + (1 + STOP2).
- DONE is at cycle B·Prescale. Data_Valid and the error flags are high during cycle B·Prescale+1, for exactly 1 cycle.
- Example: 8N1 at Prescale 8 gives Data_Valid at cycle 81.
- Back-to-back frames: the next start is accepted straight from DONE with no idle cycle required.
- A parity error and a stop error in the same frame both pulse, and Data_Valid stays 0.
- Busy is combinational from state.

## Configuration
- UART_RX_BREAK_DET_EN defined:
  - Break condition: all data bits, the parity bit (if present) and the first stop bit all decide 0.
  - On a break, DONE pulses Break_Det = 1 and Stop_Error = 1, Data_Valid = 0, and P_DATA is unchanged.
  - The FSM then enters BRK_WAIT and stays there until raw RX_In = 1, then goes to IDLE. A new start is not accepted during the break.
- Undefined: Break_Det is tied 0 and BRK_WAIT does not exist. A break frame reports only Stop_Error, then follows the normal DONE exit.

## Test plan
- 8N1, Prescale 8, byte 0xA5 → Data_Valid pulse at cycle 81, P_DATA = 0xA5, no error flags.
- 8E1, Prescale 16, byte 0x03 sent with parity 1 → Parity_Error = 1, Data_Valid = 0, P_DATA keeps its previous value.
- RX_In low for 3 cycles at Prescale 8 → FSM returns to IDLE before edge 7, no flags, Busy drops.
- DATA_WIDTH = 7, odd parity, STOP2 = 1, two back-to-back frames 0x55 then 0x2A → two Data_Valid pulses 11·Prescale cycles apart, with correct P_DATA each time.
- Line held 0 for 12 bit times → Break_Det = 1 and Stop_Error = 1 (with the macro; without it, only Stop_Error = 1). With the macro, Busy stays high until RX_In returns to 1.
- RST asserted mid-DATA → all outputs 0 immediately. The next clean frame 0x3C is received correctly.
